// File: rtl/fpga_pkg.sv
// Shared definitions for the DE2 board-level control blocks.
//   mode_e       : decoded run mode (mode[1] set means full speed)
//   step_state_e : single-step FSM states
//   decode_mode  : maps the raw 2-bit switch value onto mode_e
//   cnt_width    : counter width for a terminal count, never below 1 bit
package fpga_pkg;

   typedef enum logic [1:0] {
      MODE_STEP = 2'b00,
      MODE_SLOW = 2'b01,
      MODE_FULL = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      FIRE     = 2'b01,
      WAIT_REL = 2'b10
   } step_state_e;

   // 2'b11 is also full speed, so bit 1 dominates.
   function automatic mode_e decode_mode(input logic [1:0] m);
      if (m[1])      return MODE_FULL;
      else if (m[0]) return MODE_SLOW;
      else           return MODE_STEP;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce.sv
// Level debouncer for an already-synchronised input.
//   clk, rst_n : board clock, asynchronous active-low reset
//   din        : synchronised raw level
//   level      : debounced level, resets to 1 (released)
// The accepted level changes only after din has differed from it for
// DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module debounce
   import fpga_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level
);

   localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   // Terminal value is reached before the counter could overflow, so it
   // never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b1;
         cnt_q <= '0;
      end else if (din != level) begin
         if (cnt_q == CNT_LAST) begin
            level <= din;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/step_ctrl_de2.sv
// CPU clock-enable generator for the DE2 board: single step, slow run or
// full speed, selected by switches, with a debounced step pushbutton.
//   clk        : 50 MHz board clock (only clock)
//   rst_n      : asynchronous active-low reset
//   key_step_n : raw step pushbutton, pressed = 0
//   mode       : raw switches, 00 step / 01 slow / 1x full
//   cpu_ce     : registered clock enable for the core
//   key_level  : debounced key level (1 = released)
//   heartbeat  : toggles once per SLOW_DIV cycles in every mode
module step_ctrl_de2
   import fpga_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned SLOW_DIV        = 5_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_step_n,
   input  logic [1:0] mode,
   output logic       cpu_ce,
   output logic       key_level,
   output logic       heartbeat
);

   localparam int unsigned   SW        = cnt_width(SLOW_DIV);
   localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);

   // Two-flop synchronisers; key idles released, mode idles at step.
   logic [1:0] key_sync_q;
   logic [1:0] mode_meta_q;
   logic [1:0] mode_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_sync_q  <= '1;
         mode_meta_q <= '0;
         mode_sync_q <= '0;
      end else begin
         key_sync_q  <= {key_sync_q[0], key_step_n};
         mode_meta_q <= mode;
         mode_sync_q <= mode_meta_q;
      end
   end

   mode_e mode_s;
   always_comb mode_s = decode_mode(mode_sync_q);

   debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (key_sync_q[1]),
      .level(key_level)
   );

   // Free-running slow divider; shared by slow mode and the heartbeat,
   // deliberately unaffected by mode changes.
   logic [SW-1:0] slow_cnt_q;
   logic          slow_wrap;

   assign slow_wrap = (slow_cnt_q == SLOW_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slow_cnt_q <= '0;
         heartbeat  <= 1'b0;
      end else if (slow_wrap) begin
         slow_cnt_q <= '0;
         heartbeat  <= ~heartbeat;
      end else begin
         slow_cnt_q <= slow_cnt_q + SW'(1);
      end
   end

   // Step FSM. A press seen outside step mode is consumed via WAIT_REL, so a
   // key held across a switch into step mode cannot fire until re-pressed.
   step_state_e state_q;
   step_state_e state_d;
   logic        cpu_ce_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!key_level) begin
               state_d = (mode_s == MODE_STEP) ? FIRE : WAIT_REL;
            end
         end
         FIRE:     state_d = WAIT_REL;
         WAIT_REL: begin
            if (key_level) state_d = IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_ce_d = 1'b0;
      unique case (mode_s)
         MODE_STEP: cpu_ce_d = (state_q == FIRE);
         MODE_SLOW: cpu_ce_d = slow_wrap;
         MODE_FULL: cpu_ce_d = 1'b1;
         default:   cpu_ce_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cpu_ce  <= 1'b0;
      end else begin
         state_q <= state_d;
         cpu_ce  <= cpu_ce_d;
      end
   end

endmodule
